// File: rtl/uart_frame_tx_sched_if.sv
// Requester and byte-transmitter signal bundle for the UART frame scheduler.
// master = requesters plus byte transmitter, slave = scheduler.
interface uart_frame_tx_sched_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req;
    logic [8*NUM_REQ-1:0]  req_addr;
    logic [32*NUM_REQ-1:0] req_buyprice;
    logic [32*NUM_REQ-1:0] req_sellprice;
    logic [32*NUM_REQ-1:0] req_buyvol;
    logic [32*NUM_REQ-1:0] req_sellvol;
    logic [NUM_REQ-1:0]    req_ack;
    logic                  uart_tx_dv;
    logic [7:0]            uart_tx_data;
    logic                  uart_tx_busy;
    logic                  uart_tx_done;
    logic                  frame_done;
    logic                  sched_busy;

    modport master (
        output req, req_addr, req_buyprice, req_sellprice, req_buyvol, req_sellvol,
        output uart_tx_busy, uart_tx_done,
        input  req_ack, uart_tx_dv, uart_tx_data, frame_done, sched_busy
    );

    modport slave (
        input  req, req_addr, req_buyprice, req_sellprice, req_buyvol, req_sellvol,
        input  uart_tx_busy, uart_tx_done,
        output req_ack, uart_tx_dv, uart_tx_data, frame_done, sched_busy
    );
endinterface

// File: rtl/uart_frame_tx_sched.sv
// Round-robin frame scheduler: latches one requester's fields, emits a 19-byte frame byte by byte.
// Grant/ack one cycle after req; each byte waits for transmitter idle (busy) and its done pulse.
module uart_frame_tx_sched #(
    parameter int         NUM_REQ    = 4,
    parameter logic [7:0] START_BYTE = 8'hF0,
    parameter logic [7:0] STOP_BYTE  = 8'h0F
) (
    input  logic                  clk,
    input  logic                  reset,
    uart_frame_tx_sched_if.slave  bus
);

    localparam int         LGW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [4:0] LAST_IDX = 5'd18;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] buyprice;
        logic [31:0] sellprice;
        logic [31:0] buyvol;
        logic [31:0] sellvol;
    } frame_t;

    state_t           state;
    logic [4:0]       byte_idx;
    logic [LGW-1:0]   last_grant;
    frame_t           frame;

    logic             grant_vld;
    logic [LGW-1:0]   grant_idx;
    frame_t           req_frame;
    logic [127:0]     payload;
    logic [3:0]       pidx;
    logic [7:0]       cur_byte;

    // Round-robin search starting one past the previous winner.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!grant_vld && bus.req[(int'(last_grant) + k) % NUM_REQ]) begin
                grant_vld = 1'b1;
                grant_idx = LGW'((int'(last_grant) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        req_frame.addr      = bus.req_addr[{grant_idx, 3'b000} +: 8];
        req_frame.buyprice  = bus.req_buyprice[{grant_idx, 5'b00000} +: 32];
        req_frame.sellprice = bus.req_sellprice[{grant_idx, 5'b00000} +: 32];
        req_frame.buyvol    = bus.req_buyvol[{grant_idx, 5'b00000} +: 32];
        req_frame.sellvol   = bus.req_sellvol[{grant_idx, 5'b00000} +: 32];
    end

    // Payload bytes 2..17 walk the 128-bit word MSB first; 15-pidx == ~pidx.
    assign payload = {frame.buyprice, frame.sellprice, frame.buyvol, frame.sellvol};
    assign pidx    = 4'(byte_idx - 5'd2);

    always_comb begin
        if (byte_idx == 5'd0) begin
            cur_byte = START_BYTE;
        end else if (byte_idx == 5'd1) begin
            cur_byte = frame.addr;
        end else if (byte_idx == LAST_IDX) begin
            cur_byte = STOP_BYTE;
        end else begin
            cur_byte = payload[{~pidx, 3'b000} +: 8];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            byte_idx         <= '0;
            last_grant       <= LGW'(NUM_REQ - 1);
            frame            <= '0;
            bus.req_ack      <= '0;
            bus.uart_tx_dv   <= 1'b0;
            bus.uart_tx_data <= '0;
            bus.frame_done   <= 1'b0;
            bus.sched_busy   <= 1'b0;
        end else begin
            bus.req_ack    <= '0;
            bus.uart_tx_dv <= 1'b0;
            bus.frame_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant_vld) begin
                        frame          <= req_frame;
                        bus.req_ack    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx;
                        last_grant     <= grant_idx;
                        byte_idx       <= '0;
                        state          <= SEND;
                        bus.sched_busy <= 1'b1;
                    end
                end
                SEND: begin
                    if (!bus.uart_tx_busy) begin
                        bus.uart_tx_dv   <= 1'b1;
                        bus.uart_tx_data <= cur_byte;
                        state            <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.uart_tx_done) begin
                        if (byte_idx == LAST_IDX) begin
                            bus.frame_done <= 1'b1;
                            bus.sched_busy <= 1'b0;
                            state          <= IDLE;
                        end else begin
                            byte_idx <= byte_idx + 5'd1;
                            state    <= SEND;
                        end
                    end
                end
                default: begin
                    state          <= IDLE;
                    bus.sched_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_tx_sched.sv
// Directed bench for uart_frame_tx_sched with a 10-cycle byte transmitter model.
module tb_uart_frame_tx_sched;

    logic clk;
    logic reset;
    logic model_busy, model_done, force_busy, spur_done;
    logic [7:0] bytes[$];
    int ack_total = 0;
    int fd_total  = 0;
    int dv_total  = 0;
    int checks    = 0;
    int failures  = 0;

    uart_frame_tx_sched_if #(.NUM_REQ(4)) bus ();

    uart_frame_tx_sched #(
        .NUM_REQ(4),
        .START_BYTE(8'hF0),
        .STOP_BYTE(8'h0F)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.uart_tx_busy = model_busy | force_busy;
    assign bus.uart_tx_done = model_done | spur_done;

    // Byte transmitter model and event monitor, sampled 1 time unit after each edge.
    initial begin
        int cnt;
        cnt = 0;
        model_busy = 1'b0;
        model_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            model_done = 1'b0;
            if (reset) begin
                model_busy = 1'b0;
                cnt = 0;
            end else begin
                if (bus.req_ack != '0) ack_total++;
                if (bus.frame_done) fd_total++;
                if (bus.uart_tx_dv) begin
                    bytes.push_back(bus.uart_tx_data);
                    dv_total++;
                    model_busy = 1'b1;
                    cnt = 10;
                end else if (model_busy) begin
                    cnt--;
                    if (cnt == 0) begin
                        model_busy = 1'b0;
                        model_done = 1'b1;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("%s: check did not hold", tag);
        end
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [31:0] b,
                           input logic [31:0] s, input logic [31:0] bv, input logic [31:0] sv);
        bus.req_addr[8*i +: 8]       = a;
        bus.req_buyprice[32*i +: 32]  = b;
        bus.req_sellprice[32*i +: 32] = s;
        bus.req_buyvol[32*i +: 32]    = bv;
        bus.req_sellvol[32*i +: 32]   = sv;
    endtask

    task automatic wait_ack(input int bound);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.req_ack == '0 && n < bound);
    endtask

    task automatic wait_fd(input int bound);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.frame_done && n < bound);
    endtask

    task automatic check_frame(input string tag, input int base, input logic [7:0] a,
                               input logic [31:0] b, input logic [31:0] s,
                               input logic [31:0] bv, input logic [31:0] sv);
        logic [7:0] e [19];
        logic [7:0] obs;
        e[0]  = 8'hF0;
        e[1]  = a;
        e[18] = 8'h0F;
        for (int k = 0; k < 4; k++) begin
            e[2+k]  = b[31-8*k -: 8];
            e[6+k]  = s[31-8*k -: 8];
            e[10+k] = bv[31-8*k -: 8];
            e[14+k] = sv[31-8*k -: 8];
        end
        chk($sformatf("%s_len", tag), 64'(bytes.size() - base), 64'd19);
        for (int i = 0; i < 19; i++) begin
            if (base + i < bytes.size()) obs = bytes[base+i];
            else obs = 8'hxx;
            chk($sformatf("%s_b%0d", tag, i), obs, e[i]);
        end
    endtask

    initial begin
        int base, a0, d0, d1, d2, a2, a3, ack_start, n;
        logic [3:0] one;
        one = 4'b0001;
        reset = 1'b1;
        force_busy = 1'b0;
        spur_done = 1'b0;
        bus.req = '0;
        bus.req_addr = '0;
        bus.req_buyprice = '0;
        bus.req_sellprice = '0;
        bus.req_buyvol = '0;
        bus.req_sellvol = '0;
        repeat (3) tick();

        chk("rst_ack", bus.req_ack, 4'b0000);
        chk("rst_dv", bus.uart_tx_dv, 1'b0);
        chk("rst_data", bus.uart_tx_data, 8'h00);
        chk("rst_fd", bus.frame_done, 1'b0);
        chk("rst_busy", bus.sched_busy, 1'b0);
        reset = 1'b0;
        tick();

        // Single frame from requester 0
        set_req(0, 8'h12, 32'hA1B2C3D4, 32'h0, 32'h0, 32'h0);
        bus.req = 4'b0001;
        wait_ack(20);
        chk("t1_ack", bus.req_ack, 4'b0001);
        chk("t1_sched_busy", bus.sched_busy, 1'b1);
        base = bytes.size();
        a0 = ack_total;
        bus.req = 4'b0000;
        tick();
        chk("t1_ack_pulse", bus.req_ack, 4'b0000);
        wait_fd(400);
        chk("t1_fd", bus.frame_done, 1'b1);
        check_frame("t1", base, 8'h12, 32'hA1B2C3D4, 32'h0, 32'h0, 32'h0);
        tick();
        chk("t1_fd_pulse", bus.frame_done, 1'b0);
        chk("t1_idle", bus.sched_busy, 1'b0);
        chk("t1_one_ack", ack_total, a0);

        // All four requesting: round-robin 0,1,2,3,0 with back-to-back grants
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++)
            set_req(i, 8'h40 + 8'(i), 32'hB000_0000 | i, 32'h5E11_0000 | i, 100 + i, 200 + i);
        ack_start = ack_total;
        bus.req = 4'b1111;
        wait_ack(20);
        for (int f = 0; f < 5; f++) begin
            chk($sformatf("t2_grant%0d", f), bus.req_ack, one << (f % 4));
            base = bytes.size();
            wait_fd(400);
            chk($sformatf("t2_fd%0d", f), bus.frame_done, 1'b1);
            check_frame($sformatf("t2_f%0d", f), base, 8'h40 + 8'(f % 4),
                        32'hB000_0000 | (f % 4), 32'h5E11_0000 | (f % 4),
                        100 + (f % 4), 200 + (f % 4));
            chk($sformatf("t2_acks%0d", f), ack_total - ack_start, f + 1);
            if (f == 4) bus.req = 4'b0000;
            tick();
        end
        chk("t2_cancel", bus.req_ack, 4'b0000);

        // Spurious done while idle
        d0 = dv_total;
        spur_done = 1'b1;
        tick();
        spur_done = 1'b0;
        repeat (3) tick();
        chk("t4_idle_state", bus.sched_busy, 1'b0);
        chk("t4_idle_dv", dv_total, d0);

        // Transmitter busy for 5 cycles on entering SEND, with a spurious done inside
        force_busy = 1'b1;
        set_req(2, 8'h33, 32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'h76543210);
        bus.req = 4'b0100;
        wait_ack(20);
        chk("t3_ack", bus.req_ack, 4'b0100);
        chk("t3_dv_a0", bus.uart_tx_dv, 1'b0);
        bus.req = 4'b0000;
        base = bytes.size();
        d1 = dv_total;
        for (int k = 1; k <= 4; k++) begin
            tick();
            spur_done = (k == 2);
            chk($sformatf("t3_dv_a%0d", k), bus.uart_tx_dv, 1'b0);
        end
        tick();
        force_busy = 1'b0;
        chk("t3_dv_a5", bus.uart_tx_dv, 1'b0);
        chk("t3_in_send", bus.sched_busy, 1'b1);
        tick();
        chk("t3_dv_fire", bus.uart_tx_dv, 1'b1);
        chk("t3_first_byte", bus.uart_tx_data, 8'hF0);
        wait_fd(400);
        chk("t3_fd", bus.frame_done, 1'b1);
        check_frame("t3", base, 8'h33, 32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'h76543210);
        chk("t3_dv_count", dv_total - d1, 19);

        // Reset after byte 7 of a frame
        set_req(1, 8'h77, 32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00);
        bus.req = 4'b0010;
        wait_ack(20);
        chk("t5_ack", bus.req_ack, 4'b0010);
        bus.req = 4'b0000;
        base = bytes.size();
        n = 0;
        while (bytes.size() - base < 8 && n < 200) begin
            tick();
            n++;
        end
        chk("t5_progress", 64'(bytes.size() - base), 64'd8);
        #1 reset = 1'b1;
        #1;
        chk("t5_rst_ack", bus.req_ack, 4'b0000);
        chk("t5_rst_dv", bus.uart_tx_dv, 1'b0);
        chk("t5_rst_data", bus.uart_tx_data, 8'h00);
        chk("t5_rst_fd", bus.frame_done, 1'b0);
        chk("t5_rst_busy", bus.sched_busy, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        d2 = dv_total;
        a2 = ack_total;
        repeat (30) tick();
        chk("t5_no_dv", dv_total, d2);
        chk("t5_no_reack", ack_total, a2);
        set_req(2, 8'h5A, 32'hCAFEF00D, 32'h0BADBEEF, 32'h00000001, 32'h80000000);
        bus.req = 4'b0100;
        wait_ack(20);
        chk("t5_ack2", bus.req_ack, 4'b0100);
        bus.req = 4'b0000;
        base = bytes.size();
        wait_fd(400);
        chk("t5_fd", bus.frame_done, 1'b1);
        check_frame("t5", base, 8'h5A, 32'hCAFEF00D, 32'h0BADBEEF, 32'h00000001, 32'h80000000);

        // Payload changed after ack must not reach the wire; short-lived req[3] is dropped
        set_req(1, 8'hC1, 32'h0A0B0C0D, 32'h10203040, 32'h50607080, 32'h90A0B0C0);
        bus.req = 4'b0010;
        wait_ack(20);
        chk("t6_ack", bus.req_ack, 4'b0010);
        bus.req = 4'b0000;
        base = bytes.size();
        tick();
        set_req(1, 8'hEE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        bus.req = 4'b1000;
        repeat (5) tick();
        bus.req = 4'b0000;
        wait_fd(400);
        chk("t6_fd", bus.frame_done, 1'b1);
        check_frame("t6", base, 8'hC1, 32'h0A0B0C0D, 32'h10203040, 32'h50607080, 32'h90A0B0C0);
        a3 = ack_total;
        repeat (20) tick();
        chk("t6_cancel", ack_total, a3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_frame_tx_sched.md
UART_FRAME_TX_SCHED -- requirements
Module: uart_frame_tx_sched

Interface
REQ-001 Parameter NUM_REQ, default 4, number of frame requesters (2..8).
REQ-002 Parameter START_BYTE, default 8'hF0, frame start delimiter.
REQ-003 Parameter STOP_BYTE, default 8'h0F, frame stop delimiter.
REQ-004 clk  input  1  single clock; all logic on posedge clk.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req  input  NUM_REQ  per-requester frame request; held high until acknowledged.
REQ-007 req_addr  input  8*NUM_REQ  per-requester address field; slice i = [8i+7:8i].
REQ-008 req_buyprice, req_sellprice, req_buyvol, req_sellvol  input  32*NUM_REQ each  per-requester payload fields; slice i = [32i+31:32i].
REQ-009 req_ack  output  NUM_REQ  one-hot, one-cycle pulse; fields of that requester were latched.
REQ-010 uart_tx_dv  output  1  one-cycle strobe to the byte transmitter.
REQ-011 uart_tx_data  output  8  byte presented with uart_tx_dv.
REQ-012 uart_tx_busy  input  1  byte transmitter active.
REQ-013 uart_tx_done  input  1  one-cycle pulse; current byte fully shifted out.
REQ-014 frame_done  output  1  one-cycle pulse after the stop byte completes.
REQ-015 sched_busy  output  1  high whenever state is not IDLE.

Function
REQ-016 Frame format SHALL be 19 bytes in order: START_BYTE, addr, buyprice[31:24], [23:16], [15:8], [7:0], then sellprice, buyvol, sellvol in the same MSB-first order, then STOP_BYTE.
REQ-017 States SHALL be IDLE, SEND, WAIT; byte_idx counter 0..18 (5 bits).
REQ-018 IDLE: if req != 0, grant the first set bit searching round-robin from (last_grant+1) mod NUM_REQ; latch its addr and payload into a frame buffer; pulse req_ack[grant]; update last_grant; byte_idx<=0; go SEND.
REQ-019 The grant decision and req_ack SHALL be registered: req high at edge N gives req_ack high during cycle N+1 and the state is SEND in the same cycle.
REQ-020 SEND: when uart_tx_busy==0, drive uart_tx_dv=1 for exactly one cycle with uart_tx_data=byte[byte_idx]; go WAIT. While uart_tx_busy==1, remain in SEND with uart_tx_dv=0.
REQ-021 WAIT: on uart_tx_done, if byte_idx==18 pulse frame_done and go IDLE; else byte_idx<=byte_idx+1 and go SEND.
REQ-022 uart_tx_done seen in IDLE or SEND SHALL be ignored.
REQ-023 uart_tx_data SHALL hold its last value when uart_tx_dv==0.
REQ-024 Changes on req or req_* fields after req_ack SHALL NOT alter the frame in flight; the buffer is written only in IDLE on grant.
REQ-025 req deasserted before grant SHALL cancel that request without ack; requests arriving mid-frame wait until IDLE.
REQ-026 A requester SHALL NOT be granted twice consecutively while another requester is pending (round-robin fairness).
REQ-027 Return to IDLE and next grant: frame_done at cycle M allows req_ack at earliest cycle M+1.
REQ-028 No bytes SHALL be skipped, reordered or repeated; exactly 19 uart_tx_dv pulses per granted frame.

Reset
REQ-029 Reset asserted SHALL immediately force: state IDLE, byte_idx 0, last_grant NUM_REQ-1 (requester 0 has first priority), frame buffer 0, req_ack 0, uart_tx_dv 0, uart_tx_data 0, frame_done 0, sched_busy 0.
REQ-030 Reset mid-frame SHALL abort the frame with no further uart_tx_dv; requester is not re-acked unless it requests again.

Verification
REQ-031 req=4'b0001, addr=8'h12, buyprice=32'hA1B2C3D4, others 0; tx_done 10 cycles after each dv -> ack[0] one cycle, bytes F0 12 A1 B2 C3 D4 00x12 0F, one frame_done.
REQ-032 After reset, req=4'b1111 held continuously -> grants in order 0,1,2,3,0; each req_ack exactly once per frame.
REQ-033 uart_tx_busy held high 5 cycles on entering SEND -> uart_tx_dv waits, fires in first cycle busy is low; byte unchanged.
REQ-034 Spurious uart_tx_done in IDLE and SEND -> no state or byte_idx change, no extra dv.
REQ-035 Reset asserted after byte 7 of a frame -> all outputs 0 same cycle; after release, req=4'b0100 -> ack[2], fresh frame starting F0.
REQ-036 Requester 1 changes payload the cycle after ack[1] -> transmitted frame carries the latched (original) values.
